sdram_pattern_tester: RTL and testbench

- Parametrised SDRAM self-test master; drives the sdram_ctrl internal request interface (adr/dat/sel/acc/ack/we/idle) on the SDRAM clock domain.
- Writes a full region with a selectable data pattern, then reads the region back and compares it. Optionally loops.
- Records error count, first-failure details and completed-pass count for board bring-up, LEDs and debug readout.

---
 rtl/sdram_test_pkg.sv | 34 +++
 rtl/sdram_pattern_gen.sv | 60 ++++++
 rtl/sdram_pattern_tester.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
// Shared types and helpers for the SDRAM pattern tester.
// Optional feature macro used by the tester: SDRAM_PATTERN_TESTER_INVERT_EN.
package sdram_test_pkg;

   typedef enum logic [1:0] {
      PAT_INC   = 2'd0,
      PAT_LFSR  = 2'd1,
      PAT_WALK1 = 2'd2,
      PAT_ADR   = 2'd3
   } pattern_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_CTRL = 3'd1,
      ST_WR_REQ    = 3'd2,
      ST_WR_WAIT   = 3'd3,
      ST_RD_REQ    = 3'd4,
      ST_RD_WAIT   = 3'd5,
      ST_DONE      = 3'd6
   } tester_state_t;

   // Galois (right-shifting) feedback masks for maximal-length LFSRs.
   function automatic logic [63:0] lfsr_taps(input int width);
      case (width)
         8:       return 64'h0000_0000_0000_00B8;
         16:      return 64'h0000_0000_0000_B400;
         24:      return 64'h0000_0000_00E1_0000;
         32:      return 64'h0000_0000_8020_0003;
         64:      return 64'hD800_0000_0000_0000;
         default: return 64'h0000_0000_0000_B400;
      endcase
   endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Pattern generator shared by the write and read sweeps so that expected
// read data is regenerated instead of buffered. Holds the LFSR state; all
// other patterns are pure functions of the word index / address.
module sdram_pattern_gen
   import sdram_test_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LFSR_SEED  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  adv_i,
   input  logic [31:0]           index_i,
   input  logic [DATA_WIDTH-1:0] adr_i,
   input  pattern_mode_t         mode_i,
   input  logic                  invert_i,
   output logic [DATA_WIDTH-1:0] pattern_o
);

   localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(LFSR_SEED);
   localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
   logic [DATA_WIDTH-1:0] raw;

   // LFSR next value: reload the seed at the start of a sweep, else step once per word.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (adv_i) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
      end
   end

   // LFSR state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Pattern selection for the current word, optionally inverted.
   always_comb begin
      raw = '0;
      case (mode_i)
         PAT_INC:   raw = DATA_WIDTH'(index_i);
         PAT_LFSR:  raw = lfsr_q;
         PAT_WALK1: raw = ONE << (index_i % 32'(DATA_WIDTH));
         PAT_ADR:   raw = adr_i;
         default:   raw = '0;
      endcase
      pattern_o = invert_i ? ~raw : raw;
   end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test master: writes a region with a pattern, reads it back and
// compares, optionally looping. Records error/pass counts and first failure.
// Macro SDRAM_PATTERN_TESTER_INVERT_EN adds an inverted-data sweep per pass.
module sdram_pattern_tester
   import sdram_test_pkg::*;
#(
   parameter int          DATA_WIDTH    = 16,
   parameter int          ADR_WIDTH     = 25,
   parameter int          ADR_STEP      = 2,
   parameter logic [31:0] START_ADR     = 32'h0,
   parameter int          WORD_COUNT    = 1024,
   parameter int          LFSR_SEED     = 1,
   parameter int          ACK_TIMEOUT   = 4096,
   parameter int          ERR_CNT_WIDTH = 16
) (
   input  logic                     sdram_clk,
   input  logic                     sdram_rst,
   input  logic                     start_i,
   input  logic [1:0]               mode_i,
   input  logic                     loop_i,
   input  logic                     idle_i,
   output logic [31:0]              adr_o,
   output logic [DATA_WIDTH-1:0]    dat_o,
   input  logic [DATA_WIDTH-1:0]    dat_i,
   output logic [DATA_WIDTH/8-1:0]  sel_o,
   output logic                     acc_o,
   input  logic                     ack_i,
   output logic                     we_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     error_o,
   output logic                     timeout_o,
   output logic [ERR_CNT_WIDTH-1:0] err_count_o,
   output logic [ERR_CNT_WIDTH-1:0] pass_count_o,
   output logic [31:0]              fail_adr_o,
   output logic [DATA_WIDTH-1:0]    fail_exp_o,
   output logic [DATA_WIDTH-1:0]    fail_got_o
);

   // Handshake: a request is presented by raising acc_o with adr_o/dat_o/we_o
   // held stable; it completes on the first cycle ack_i is sampled high while
   // acc_o is high, and acc_o drops on the following cycle. ack_i while acc_o
   // is low is ignored, and every request is separated by an acc_o-low cycle.

   localparam logic [31:0] ADR_MASK = (ADR_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                      ((32'd1 << ADR_WIDTH) - 32'd1);
   localparam logic [31:0] STEP_W   = 32'(ADR_STEP);
   localparam logic [31:0] LAST_IDX = 32'(WORD_COUNT - 1);
   localparam logic [31:0] TO_LAST  = 32'(ACK_TIMEOUT - 1);
   localparam bit          TO_EN    = (ACK_TIMEOUT != 0);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

   tester_state_t             state_q, state_d;
   pattern_mode_t             mode_q, mode_d;
   logic [31:0]               index_q, index_d;
   logic [31:0]               to_cnt_q, to_cnt_d;
   logic [31:0]               adr_q, adr_d;
   logic [DATA_WIDTH-1:0]     dat_q, dat_d;
   logic                      acc_q, acc_d;
   logic                      we_q, we_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      error_q, error_d;
   logic                      timeout_q, timeout_d;
   logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
   logic [ERR_CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
   logic [31:0]               fail_adr_q, fail_adr_d;
   logic [DATA_WIDTH-1:0]     fail_exp_q, fail_exp_d;
   logic [DATA_WIDTH-1:0]     fail_got_q, fail_got_d;

   logic                      lfsr_load, lfsr_adv;
   logic                      inv_w;
   logic                      to_hit;
   logic                      finish_pass;
   logic [31:0]               cur_adr;
   logic [DATA_WIDTH-1:0]     cur_adr_dat;
   logic [DATA_WIDTH-1:0]     pattern;

`ifdef SDRAM_PATTERN_TESTER_INVERT_EN
   logic inv_q, inv_d;
   assign inv_w = inv_q;
`else
   assign inv_w = 1'b0;
`endif

   assign cur_adr     = (START_ADR + index_q * STEP_W) & ADR_MASK;
   assign cur_adr_dat = DATA_WIDTH'(cur_adr);
   assign to_hit      = TO_EN && (to_cnt_q == TO_LAST);

   sdram_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .LFSR_SEED  (LFSR_SEED)
   ) u_gen (
      .clk       (sdram_clk),
      .rst       (sdram_rst),
      .load_i    (lfsr_load),
      .adv_i     (lfsr_adv),
      .index_i   (index_q),
      .adr_i     (cur_adr_dat),
      .mode_i    (mode_q),
      .invert_i  (inv_w),
      .pattern_o (pattern)
   );

   // Next-state and registered-output logic for the test sequencer.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      index_d     = index_q;
      to_cnt_d    = to_cnt_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      acc_d       = acc_q;
      we_d        = we_q;
      done_d      = done_q;
      error_d     = error_q;
      timeout_d   = timeout_q;
      err_cnt_d   = err_cnt_q;
      pass_cnt_d  = pass_cnt_q;
      fail_adr_d  = fail_adr_q;
      fail_exp_d  = fail_exp_q;
      fail_got_d  = fail_got_q;
      lfsr_load   = 1'b0;
      lfsr_adv    = 1'b0;
      finish_pass = 1'b0;
`ifdef SDRAM_PATTERN_TESTER_INVERT_EN
      inv_d       = inv_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d    = ST_WAIT_CTRL;
               mode_d     = pattern_mode_t'(mode_i);
               done_d     = 1'b0;
               error_d    = 1'b0;
               timeout_d  = 1'b0;
               err_cnt_d  = '0;
               pass_cnt_d = '0;
               fail_adr_d = '0;
               fail_exp_d = '0;
               fail_got_d = '0;
            end
         end
         ST_WAIT_CTRL: begin
            if (idle_i) begin
               state_d   = ST_WR_REQ;
               index_d   = '0;
               lfsr_load = 1'b1;
`ifdef SDRAM_PATTERN_TESTER_INVERT_EN
               inv_d     = 1'b0;
`endif
            end
         end
         ST_WR_REQ: begin
            acc_d    = 1'b1;
            we_d     = 1'b1;
            adr_d    = cur_adr;
            dat_d    = pattern;
            to_cnt_d = '0;
            state_d  = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            if (acc_q && ack_i) begin
               acc_d = 1'b0;
               we_d  = 1'b0;
               if (index_q == LAST_IDX) begin
                  index_d   = '0;
                  lfsr_load = 1'b1;
                  state_d   = ST_RD_REQ;
               end else begin
                  index_d   = index_q + 32'd1;
                  lfsr_adv  = 1'b1;
                  state_d   = ST_WR_REQ;
               end
            end else if (to_hit) begin
               acc_d     = 1'b0;
               we_d      = 1'b0;
               timeout_d = 1'b1;
               error_d   = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else begin
               to_cnt_d  = to_cnt_q + 32'd1;
            end
         end
         ST_RD_REQ: begin
            acc_d    = 1'b1;
            we_d     = 1'b0;
            adr_d    = cur_adr;
            to_cnt_d = '0;
            state_d  = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (acc_q && ack_i) begin
               acc_d = 1'b0;
               if (dat_i != pattern) begin
                  error_d = 1'b1;
                  if (err_cnt_q != ERR_MAX) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
                  // A zero error count means this is the first miscompare since start.
                  if (err_cnt_q == '0) begin
                     fail_adr_d = adr_q;
                     fail_exp_d = pattern;
                     fail_got_d = dat_i;
                  end
               end
               if (index_q == LAST_IDX) begin
                  index_d   = '0;
                  lfsr_load = 1'b1;
`ifdef SDRAM_PATTERN_TESTER_INVERT_EN
                  if (!inv_q) begin
                     inv_d   = 1'b1;
                     state_d = ST_WR_REQ;
                  end else begin
                     inv_d       = 1'b0;
                     finish_pass = 1'b1;
                  end
`else
                  finish_pass = 1'b1;
`endif
                  if (finish_pass) begin
                     pass_cnt_d = pass_cnt_q + 1'b1;
                     if (loop_i) begin
                        state_d = ST_WR_REQ;
                     end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                     end
                  end
               end else begin
                  index_d  = index_q + 32'd1;
                  lfsr_adv = 1'b1;
                  state_d  = ST_RD_REQ;
               end
            end else if (to_hit) begin
               acc_d     = 1'b0;
               we_d      = 1'b0;
               timeout_d = 1'b1;
               error_d   = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else begin
               to_cnt_d  = to_cnt_q + 32'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
   end

   // State and output registers; reset leaves every output low.
   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= PAT_INC;
         index_q    <= '0;
         to_cnt_q   <= '0;
         adr_q      <= '0;
         dat_q      <= '0;
         acc_q      <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         timeout_q  <= 1'b0;
         err_cnt_q  <= '0;
         pass_cnt_q <= '0;
         fail_adr_q <= '0;
         fail_exp_q <= '0;
         fail_got_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         index_q    <= index_d;
         to_cnt_q   <= to_cnt_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         acc_q      <= acc_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         timeout_q  <= timeout_d;
         err_cnt_q  <= err_cnt_d;
         pass_cnt_q <= pass_cnt_d;
         fail_adr_q <= fail_adr_d;
         fail_exp_q <= fail_exp_d;
         fail_got_q <= fail_got_d;
      end
   end

`ifdef SDRAM_PATTERN_TESTER_INVERT_EN
   // Sweep polarity register for the inverted-data sweep.
   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         inv_q <= 1'b0;
      end else begin
         inv_q <= inv_d;
      end
   end
`endif

   assign adr_o        = adr_q;
   assign dat_o        = dat_q;
   assign sel_o        = '1;
   assign acc_o        = acc_q;
   assign we_o         = we_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign timeout_o    = timeout_q;
   assign err_count_o  = err_cnt_q;
   assign pass_count_o = pass_cnt_q;
   assign fail_adr_o   = fail_adr_q;
   assign fail_exp_o   = fail_exp_q;
   assign fail_got_o   = fail_got_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Self-checking bench for sdram_pattern_tester with a behavioural SDRAM model
// (random ack latency, spurious acks while idle, optional word corruption).
module tb_sdram_pattern_tester;

  localparam int WC   = 20;
  localparam int AT   = 8;
  localparam int STEP = 2;
`ifdef SDRAM_PATTERN_TESTER_INVERT_EN
  localparam int SWEEPS = 2;
`else
  localparam int SWEEPS = 1;
`endif

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  mode_i;
  logic        loop_i;
  logic        idle_i;
  logic [31:0] adr_o;
  logic [15:0] dat_o;
  logic [15:0] dat_i;
  logic [1:0]  sel_o;
  logic        acc_o;
  logic        ack_i;
  logic        we_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        timeout_o;
  logic [15:0] err_count_o;
  logic [15:0] pass_count_o;
  logic [31:0] fail_adr_o;
  logic [15:0] fail_exp_o;
  logic [15:0] fail_got_o;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  logic [48:0] exp_q[$];
  logic [15:0] mem [logic [31:0]];
  logic [31:0] corrupt_adr = 32'hFFFF_FFFF;
  logic [15:0] corrupt_mask = 16'h0;
  bit          ack_en = 1'b1;
  bit          spur_en = 1'b1;
  int          max_lat = 3;

  sdram_pattern_tester #(
    .DATA_WIDTH    (16),
    .ADR_WIDTH     (25),
    .ADR_STEP      (STEP),
    .START_ADR     (32'h0),
    .WORD_COUNT    (WC),
    .LFSR_SEED     (1),
    .ACK_TIMEOUT   (AT),
    .ERR_CNT_WIDTH (16)
  ) dut (
    .sdram_clk    (clk),
    .sdram_rst    (rst),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .loop_i       (loop_i),
    .idle_i       (idle_i),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .dat_i        (dat_i),
    .sel_o        (sel_o),
    .acc_o        (acc_o),
    .ack_i        (ack_i),
    .we_o         (we_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .timeout_o    (timeout_o),
    .err_count_o  (err_count_o),
    .pass_count_o (pass_count_o),
    .fail_adr_o   (fail_adr_o),
    .fail_exp_o   (fail_exp_o),
    .fail_got_o   (fail_got_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] ref_adr(input int i);
    logic [31:0] a;
    a = 32'(i) * 32'(STEP);
    return a & 32'h01FF_FFFF;
  endfunction

  function automatic logic [15:0] ref_data(input int mode, input int i, input bit inv);
    logic [15:0] d;
    logic [15:0] l;
    logic [31:0] a;
    l = 16'h0001;
    case (mode)
      0: d = 16'(i);
      1: begin
        for (int k = 0; k < i; k++) l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        d = l;
      end
      2: d = 16'h0001 << (i % 16);
      default: begin
        a = ref_adr(i);
        d = a[15:0];
      end
    endcase
    return inv ? ~d : d;
  endfunction

  task automatic build_pass(input int mode);
    for (int s = 0; s < SWEEPS; s++) begin
      for (int i = 0; i < WC; i++) exp_q.push_back({1'b1, ref_adr(i), ref_data(mode, i, s != 0)});
      for (int i = 0; i < WC; i++) exp_q.push_back({1'b0, ref_adr(i), 16'h0000});
    end
  endtask

  // SDRAM model / scoreboard on each completed request
  initial begin : responder
    bit in_req;
    int wait_cnt;
    logic [48:0] e;
    in_req = 1'b0;
    wait_cnt = 0;
    ack_i = 1'b0;
    dat_i = 16'h0;
    forever begin
      @(negedge clk);
      ack_i = 1'b0;
      if (rst) begin
        in_req = 1'b0;
      end else if (acc_o) begin
        if (!in_req) begin
          in_req = 1'b1;
          wait_cnt = $urandom_range(0, max_lat);
        end
        if (ack_en) begin
          if (wait_cnt == 0) begin
            in_req = 1'b0;
            ack_i = 1'b1;
            check("txn_expected_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("txn_we", we_o, e[48]);
              check("txn_adr", adr_o, e[47:16]);
              if (e[48]) check("txn_wdat", dat_o, e[15:0]);
            end
            if (we_o) mem[adr_o] = dat_o;
            else dat_i = (mem.exists(adr_o) ? mem[adr_o] : 16'hDEAD) ^
                         ((adr_o == corrupt_adr) ? corrupt_mask : 16'h0000);
          end else begin
            wait_cnt--;
          end
        end
      end else begin
        in_req = 1'b0;
        if (spur_en && ($urandom_range(0, 3) == 0)) ack_i = 1'b1;
      end
    end
  end

  // request fields must hold while acc_o is high
  logic [48:0] prev_req;
  bit prev_acc = 1'b0;
  always @(negedge clk) begin
    if (!rst && acc_o && prev_acc) check("req_stable", {we_o, adr_o, dat_o}, prev_req);
    prev_req = {we_o, adr_o, dat_o};
    prev_acc = acc_o && !rst;
  end

  // driver tasks
  task automatic start_test(input int mode);
    @(negedge clk);
    mode_i = 2'(mode);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    mode_i = 2'($urandom_range(0, 3));
    check("busy_after_start", busy_o, 1);
    check("done_cleared_on_start", done_o, 0);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done_o, 1);
    @(negedge clk);
  endtask

  task automatic run_test(input int mode, input int cidx, input logic [15:0] cmask);
    logic [31:0] e_fadr;
    logic [15:0] e_fexp;
    logic [15:0] e_fgot;
    int e_err;
    exp_q.delete();
    mem.delete();
    corrupt_adr = (cidx >= 0) ? ref_adr(cidx) : 32'hFFFF_FFFF;
    corrupt_mask = cmask;
    e_err  = (cidx >= 0) ? SWEEPS : 0;
    e_fadr = (cidx >= 0) ? ref_adr(cidx) : 32'h0;
    e_fexp = (cidx >= 0) ? ref_data(mode, cidx, 1'b0) : 16'h0;
    e_fgot = (cidx >= 0) ? (e_fexp ^ cmask) : 16'h0;
    build_pass(mode);
    start_test(mode);
    wait_done(5000);
    check("end_done", done_o, 1);
    check("end_busy", busy_o, 0);
    check("end_acc", acc_o, 0);
    check("end_error", error_o, e_err != 0);
    check("end_timeout", timeout_o, 0);
    check("end_err_count", err_count_o, e_err);
    check("end_pass_count", pass_count_o, 1);
    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_fail_adr", fail_adr_o, e_fadr);
    check("end_fail_exp", fail_exp_o, e_fexp);
    check("end_fail_got", fail_got_o, e_fgot);
    corrupt_adr = 32'hFFFF_FFFF;
  endtask

  initial begin : main
    int n;
    int hi;
    int m;
    rst = 1'b1;
    start_i = 1'b0;
    mode_i = 2'd0;
    loop_i = 1'b0;
    idle_i = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_sel", sel_o, 2'b11);
    check("rst_acc", acc_o, 0);
    check("rst_we", we_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_err_count", err_count_o, 0);
    check("rst_pass_count", pass_count_o, 0);
    check("rst_fail", {fail_adr_o, fail_exp_o, fail_got_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed patterns
    run_test(0, -1, 16'h0);
    run_test(3, 5, 16'h0008);
    check("corrupt_fail_adr_0a", fail_adr_o, 32'h0000_000A);
    check("corrupt_fail_exp_0a", fail_exp_o, 16'h000A);
    check("corrupt_fail_got_02", fail_got_o, 16'h0002);
    run_test(1, -1, 16'h0);
    run_test(2, -1, 16'h0);

    // randomized passes
    for (int r = 0; r < 6; r++) begin
      max_lat = $urandom_range(0, 4);
      run_test($urandom_range(0, 3),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, WC - 1)) : -1,
               16'($urandom_range(1, 65535)));
    end
    max_lat = 3;

    // looping for three passes, with a start pulse mid-run that must be ignored
    m = $urandom_range(0, 3);
    exp_q.delete();
    mem.delete();
    for (int p = 0; p < 3; p++) build_pass(m);
    loop_i = 1'b1;
    start_test(m);
    repeat (7) @(negedge clk);
    mode_i = 2'(m + 1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (pass_count_o != 16'd2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("loop_pass_two", pass_count_o, 2);
    check("loop_still_busy", busy_o, 1);
    loop_i = 1'b0;
    wait_done(5000);
    check("loop_pass_count", pass_count_o, 3);
    check("loop_done", done_o, 1);
    check("loop_error", error_o, 0);
    check("loop_exp_q_empty", exp_q.size(), 0);

    // controller not ready: no request until idle_i rises
    idle_i = 1'b0;
    exp_q.delete();
    mem.delete();
    build_pass(0);
    start_test(0);
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (acc_o) hi++;
    end
    check("idle_wait_no_acc", hi, 0);
    check("idle_wait_busy", busy_o, 1);
    idle_i = 1'b1;
    wait_done(5000);
    check("idle_wait_pass_count", pass_count_o, 1);
    check("idle_wait_exp_q_empty", exp_q.size(), 0);

    // ack timeout
    ack_en = 1'b0;
    exp_q.delete();
    build_pass(0);
    start_test(0);
    n = 0;
    while (!acc_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_acc_rose", acc_o, 1);
    hi = 0;
    while (acc_o && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("timeout_acc_cycles", hi, AT);
    check("timeout_flag", timeout_o, 1);
    check("timeout_error", error_o, 1);
    check("timeout_done", done_o, 1);
    check("timeout_busy", busy_o, 0);
    check("timeout_we", we_o, 0);
    check("timeout_pass_count", pass_count_o, 0);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    run_test(0, -1, 16'h0);

    // reset in the middle of the write sweep
    exp_q.delete();
    mem.delete();
    build_pass(1);
    start_test(1);
    n = 0;
    while (!(acc_o && we_o && adr_o == 32'h6) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midwrite_reached", {acc_o, we_o, adr_o}, {2'b11, 32'h6});
    #2 rst = 1'b1;
    #1;
    check("async_rst_acc", acc_o, 0);
    check("async_rst_we", we_o, 0);
    check("async_rst_adr", adr_o, 0);
    check("async_rst_dat", dat_o, 0);
    check("async_rst_sel", sel_o, 2'b11);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_flags", {done_o, error_o, timeout_o}, 0);
    check("async_rst_counts", {err_count_o, pass_count_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_test(2, 3, 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
